vga_mem_responder: RTL and testbench

//  Responder end of the VGA CSR read interface: serves the sequencer's 16-bit

---
 rtl/vga_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_vga_mem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_responder.sv
// rtl/vga_mem_responder.sv - VGA CSR fetch responder sharing an async SRAM with a Wishbone CPU port
// CSR fetches have fixed 2-edge latency and preempt any CPU cycle, which is retried from IDLE.
module vga_mem_responder #(
  parameter int AW = 17,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] csr_adr_i,
  input  logic          csr_stb_i,
  output logic [DW-1:0] csr_dat_o,
  output logic          csr_err_o,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [1:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic [AW-1:0] sram_addr_o,
  input  logic [DW-1:0] sram_dq_i,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [1:0]    sram_bw_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_CSR1, S_CSR2, S_CPU_RD1, S_CPU_RD2,
    S_CPU_WR1, S_CPU_WR2, S_CPU_WR3, S_ACK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_csr_dat;
  logic [DW-1:0] r_wb_dat;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dq_o;
  logic          r_dq_oe;
  logic          r_ce_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic [1:0]    r_bw_n;
  logic          r_ack;
  logic          r_err;

  logic          w_cpu_req;
  logic          w_cpu_start;
  logic          w_ce_n;
  logic          w_oe_n;
  logic          w_we_n;
  logic          w_dq_oe;
  logic [1:0]    w_bw_n;
  logic          w_ack;

  assign w_cpu_req = wb_cyc_i & wb_stb_i;

  always_comb begin
    w_state_nxt = r_state;
    if (csr_stb_i && r_state != S_CSR1) begin
      w_state_nxt = S_CSR1;
    end else begin
      case (r_state)
        S_IDLE:    if (w_cpu_req) w_state_nxt = wb_we_i ? S_CPU_WR1 : S_CPU_RD1;
        S_CSR1:    w_state_nxt = S_CSR2;
        S_CSR2:    w_state_nxt = S_IDLE;
        S_CPU_RD1: w_state_nxt = S_CPU_RD2;
        S_CPU_RD2: w_state_nxt = S_ACK;
        S_CPU_WR1: w_state_nxt = S_CPU_WR2;
        S_CPU_WR2: w_state_nxt = S_CPU_WR3;
        S_CPU_WR3: w_state_nxt = S_ACK;
        S_ACK:     w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_cpu_start = (r_state == S_IDLE) &&
                       (w_state_nxt == S_CPU_RD1 || w_state_nxt == S_CPU_WR1);

  // SRAM strobes are decoded from the next state and registered so the pads see clean edges.
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_dq_oe = 1'b0;
    w_bw_n  = 2'b11;
    w_ack   = 1'b0;
    case (w_state_nxt)
      S_CSR1, S_CSR2, S_CPU_RD1, S_CPU_RD2: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
      end
      S_CPU_WR1: begin
        w_ce_n  = 1'b0;
        w_dq_oe = 1'b1;
        w_bw_n  = ~wb_sel_i;
      end
      S_CPU_WR2: begin
        w_ce_n  = 1'b0;
        w_we_n  = 1'b0;
        w_dq_oe = 1'b1;
        w_bw_n  = r_bw_n;
      end
      S_CPU_WR3: begin
        w_ce_n  = 1'b0;
        w_dq_oe = 1'b1;
        w_bw_n  = r_bw_n;
      end
      S_ACK:   w_ack = 1'b1;
      default: w_ack = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_csr_dat <= '0;
      r_wb_dat  <= '0;
      r_addr    <= '0;
      r_dq_o    <= '0;
      r_dq_oe   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_bw_n    <= 2'b11;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dq_oe <= w_dq_oe;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_bw_n  <= w_bw_n;
      r_ack   <= w_ack;
      if (w_state_nxt == S_CSR1) begin
        r_addr <= csr_adr_i;
      end else if (w_cpu_start) begin
        r_addr <= wb_adr_i;
      end
      if (w_cpu_start && wb_we_i) begin
        r_dq_o <= wb_dat_i;
      end
      if (r_state == S_CSR2) begin
        r_csr_dat <= sram_dq_i;
      end
      if (r_state == S_CPU_RD2 && w_state_nxt == S_ACK) begin
        r_wb_dat <= sram_dq_i;
      end
      if (r_state == S_CSR1 && csr_stb_i) begin
        r_err <= 1'b1;
      end
    end
  end

  assign csr_dat_o   = r_csr_dat;
  assign csr_err_o   = r_err;
  assign wb_dat_o    = r_wb_dat;
  assign wb_ack_o    = r_ack;
  assign sram_addr_o = r_addr;
  assign sram_dq_o   = r_dq_o;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_bw_n   = r_bw_n;

endmodule

// File: tb/tb_vga_mem_responder.sv
// tb/tb_vga_mem_responder.sv - directed and randomized checks of vga_mem_responder against an SRAM and memory model
module tb_vga_mem_responder;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] csr_adr_i;
  logic          csr_stb_i;
  logic [DW-1:0] csr_dat_o;
  logic          csr_err_o;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [1:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_dq_i;
  logic [DW-1:0] sram_dq_o;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [1:0]    sram_bw_n;

  logic [15:0] sram    [0:DEPTH-1];
  logic [15:0] ref_mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  int we_pulses = 0;
  logic [15:0] last_csr;

  vga_mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .csr_adr_i(csr_adr_i), .csr_stb_i(csr_stb_i), .csr_dat_o(csr_dat_o), .csr_err_o(csr_err_o),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_bw_n(sram_bw_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: reads are combinational, writes commit mid-way through a we_n low cycle.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr_o] : 16'hDEAD;

  always @(negedge clk) begin
    if (!rst && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_bw_n[0]) sram[sram_addr_o][7:0]  = sram_dq_o[7:0];
      if (!sram_bw_n[1]) sram[sram_addr_o][15:8] = sram_dq_o[15:8];
    end
    if (wb_ack_o) ack_total++;
  end

  always @(negedge sram_we_n) we_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_csr = 16'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s csr_dat", tag), csr_dat_o, 0);
    chk($sformatf("%s wb_dat", tag), wb_dat_o, 0);
    chk($sformatf("%s addr", tag), sram_addr_o, 0);
    chk($sformatf("%s dq_o", tag), sram_dq_o, 0);
    chk($sformatf("%s ack/err/oe", tag), {wb_ack_o, csr_err_o, sram_dq_oe}, 0);
    chk($sformatf("%s ce/oe/we/bw", tag), {sram_ce_n, sram_oe_n, sram_we_n, sram_bw_n}, 5'b11111);
  endtask

  task automatic csr_fetch(input logic [AW-1:0] adr, input string tag);
    logic [15:0] exp;
    exp = ref_mem[adr];
    csr_stb_i = 1'b1;
    csr_adr_i = adr;
    tick();
    csr_stb_i = 1'b0;
    chk($sformatf("%s early0", tag), csr_dat_o, last_csr);
    tick();
    chk($sformatf("%s early1", tag), csr_dat_o, last_csr);
    tick();
    chk($sformatf("%s data", tag), csr_dat_o, exp);
    last_csr = exp;
  endtask

  // One CPU access; pre_k >= 0 pulses a CSR strobe on loop edge pre_k to preempt it.
  task automatic cpu_op(input logic we, input logic [AW-1:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input int pre_k, input logic [AW-1:0] cadr,
                        input string tag);
    int acks;
    int i;
    bit done;
    logic [15:0] exp_rd;
    logic [15:0] exp_csr;
    acks = 0;
    i = 0;
    done = 0;
    exp_rd = ref_mem[adr];
    exp_csr = ref_mem[cadr];
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    while (!done && i < 40) begin
      csr_stb_i = (i == pre_k);
      csr_adr_i = cadr;
      tick();
      csr_stb_i = 1'b0;
      if (wb_ack_o) begin
        acks++;
        if (!we) chk($sformatf("%s rdata", tag), wb_dat_o, exp_rd);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      if (pre_k >= 0 && i == pre_k + 2) begin
        chk($sformatf("%s csr", tag), csr_dat_o, exp_csr);
        last_csr = exp_csr;
      end
      i++;
      if (acks > 0 && i > pre_k + 2) done = 1;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
    if (wb_ack_o) acks++;
    chk($sformatf("%s acks", tag), acks, 1);
    if (we) begin
      if (sel[0]) ref_mem[adr][7:0]  = dat[7:0];
      if (sel[1]) ref_mem[adr][15:8] = dat[15:8];
    end
  endtask

  initial begin
    int ack0;
    int p0;
    int acks;
    logic [15:0] old;
    logic [15:0] val;

    rst = 1'b1;
    csr_adr_i = '0; csr_stb_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 2'b00; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      val = 16'($urandom);
      sram[a] = val;
      ref_mem[a] = val;
    end
    sram[17'h00123] = 16'hBEEF;
    ref_mem[17'h00123] = 16'hBEEF;
    do_reset();
    check_reset_outputs("reset");

    // Single fetch with exact latency
    csr_fetch(17'h00123, "t1");
    chk("t1 err", csr_err_o, 0);

    // Back-to-back fetches every 2 cycles while a CPU read waits
    ack0 = ack_total;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 17'h00050;
    for (int k = 0; k < 8; k++) begin
      csr_stb_i = 1'b1;
      csr_adr_i = AW'(k);
      tick();
      csr_stb_i = 1'b0;
      if (k > 0) chk($sformatf("t2 word%0d", k - 1), csr_dat_o, ref_mem[k - 1]);
      tick();
    end
    tick();
    chk("t2 word7", csr_dat_o, ref_mem[7]);
    chk("t2 no ack in burst", ack_total, ack0);
    chk("t2 err", csr_err_o, 0);
    acks = 0;
    for (int n = 0; n < 10 && acks == 0; n++) begin
      tick();
      if (wb_ack_o) begin
        acks++;
        chk("t2 cpu rdata", wb_dat_o, ref_mem[17'h00050]);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("t2 cpu ack", acks, 1);
    tick();
    last_csr = ref_mem[7];

    // Strobes on consecutive cycles: second ignored, error sticky
    csr_stb_i = 1'b1; csr_adr_i = 17'h00002;
    tick();
    csr_adr_i = 17'h00003;
    tick();
    csr_stb_i = 1'b0;
    chk("t3 err set", csr_err_o, 1);
    tick();
    chk("t3 data", csr_dat_o, ref_mem[2]);
    tick();
    chk("t3 data hold", csr_dat_o, ref_mem[2]);
    chk("t3 idle ce_n", sram_ce_n, 1);
    tick();
    tick();
    chk("t3 err sticky", csr_err_o, 1);
    do_reset();
    chk("t3 err cleared", csr_err_o, 0);

    // CPU write with one byte lane, then readback
    old = ref_mem[17'h00040];
    p0 = we_pulses;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 17'h00040; wb_dat_i = 16'h1234; wb_sel_i = 2'b01;
    tick();
    chk("t4 wr1 addr", sram_addr_o, 17'h00040);
    chk("t4 wr1 ctl", {sram_ce_n, sram_we_n, sram_dq_oe, sram_bw_n}, 5'b01110);
    chk("t4 wr1 dq", sram_dq_o, 16'h1234);
    chk("t4 wr1 ack", wb_ack_o, 0);
    tick();
    chk("t4 wr2 we_n", sram_we_n, 0);
    tick();
    chk("t4 wr3 ctl", {sram_we_n, sram_dq_oe, wb_ack_o}, 3'b110);
    tick();
    chk("t4 ack", {wb_ack_o, sram_dq_oe}, 2'b10);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk("t4 ack width", wb_ack_o, 0);
    chk("t4 we pulses", we_pulses - p0, 1);
    ref_mem[17'h00040][7:0] = 8'h34;
    cpu_op(1'b0, 17'h00040, 16'h0, 2'b00, -1, 17'h0, "t4 rb");
    chk("t4 rb merge", ref_mem[17'h00040], {old[15:8], 8'h34});

    // CSR strobe during CPU_WR2 aborts and the write is retried
    ack0 = ack_total;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 17'h00041; wb_dat_i = 16'hA5C3; wb_sel_i = 2'b11;
    tick();
    tick();
    chk("t5 in wr2", sram_we_n, 0);
    csr_stb_i = 1'b1; csr_adr_i = 17'h00123;
    tick();
    csr_stb_i = 1'b0;
    chk("t5 abort ctl", {sram_we_n, sram_dq_oe, wb_ack_o, sram_oe_n}, 4'b1000);
    chk("t5 abort addr", sram_addr_o, 17'h00123);
    tick();
    chk("t5 csr early", csr_dat_o, last_csr);
    tick();
    chk("t5 csr data", csr_dat_o, 16'hBEEF);
    last_csr = 16'hBEEF;
    chk("t5 no ack yet", ack_total, ack0);
    acks = 0;
    for (int n = 0; n < 12 && acks == 0; n++) begin
      tick();
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk("t5 one ack", ack_total - ack0, 1);
    ref_mem[17'h00041] = 16'hA5C3;
    cpu_op(1'b0, 17'h00041, 16'h0, 2'b00, -1, 17'h0, "t5 rb");

    // Reset during CPU_RD2
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 17'h00010;
    tick();
    tick();
    chk("t6 in rd2", {sram_ce_n, sram_oe_n}, 2'b00);
    ack0 = ack_total;
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    last_csr = 16'h0;
    tick();
    tick();
    tick();
    chk("t6 no ack", ack_total, ack0);
    chk("t6 idle", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);

    // Randomized mix against the memory model
    for (int r = 0; r < 40; r++) begin
      int op;
      int pk;
      logic [AW-1:0] a;
      logic [AW-1:0] ca;
      op = int'($urandom_range(0, 2));
      pk = int'($urandom_range(0, 5)) - 1;
      a = AW'($urandom_range(0, 63));
      ca = AW'(17'h00100 + $urandom_range(0, 255));
      case (op)
        0: csr_fetch(a, $sformatf("rnd%0d fetch", r));
        1: cpu_op(1'b1, a, 16'($urandom), 2'($urandom), pk, ca, $sformatf("rnd%0d wr", r));
        default: cpu_op(1'b0, a, 16'h0, 2'b00, pk, ca, $sformatf("rnd%0d rd", r));
      endcase
    end
    for (int a = 0; a < 64; a++) begin
      cpu_op(1'b0, AW'(a), 16'h0, 2'b00, -1, 17'h0, $sformatf("final rd%0d", a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
